// File: rtl/res_fifo_param_if.sv
// Handshake bundle for the result FIFO: write/read requests, data and status flags.
// The master side drives requests; the slave side (the FIFO) drives data and status.
interface res_fifo_param_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1352
);
    logic                       clear;
    logic                       wenable;
    logic [DATA_W-1:0]          result_in;
    logic                       renable;
    logic [DATA_W-1:0]          result_out;
    logic                       rvalid;
    logic                       empty;
    logic                       full;
    logic                       almost_full;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output clear, wenable, result_in, renable,
        input  result_out, rvalid, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  clear, wenable, result_in, renable,
        output result_out, rvalid, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/res_fifo_param.sv
// Result FIFO of arbitrary (non power-of-two) depth with registered read data,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
module res_fifo_param #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 1352,
    parameter int AF_LEVEL = DEPTH - 4
) (
    input  logic            clk,
    input  logic            rst,
    res_fifo_param_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] out_q;
    logic              rvalid_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              is_empty;
    logic              is_full;
    logic              rd_ok;
    logic              wr_ok;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    assign rd_ok    = bus.renable && !is_empty;
    assign wr_ok    = bus.wenable && (!is_full || rd_ok);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok && !bus.clear) begin
            mem[wptr] <= bus.result_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            out_q       <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clear) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            out_q       <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= next_ptr(wptr);
            end
            if (rd_ok) begin
                out_q    <= mem[rptr];
                rvalid_q <= 1'b1;
                rptr     <= next_ptr(rptr);
            end else begin
                out_q    <= '0;
                rvalid_q <= 1'b0;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.wenable && !wr_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.renable && !rd_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.result_out  = out_q;
    assign bus.rvalid      = rvalid_q;
    assign bus.count       = count_q;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (count_q >= CW'(AF_LEVEL));
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_res_fifo_param.sv
// Self-checking bench for res_fifo_param: directed vector table, reset and corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_res_fifo_param;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 1352;
    localparam int AF_LEVEL = DEPTH - 4;

    logic tb_clk = 1'b0;
    logic rst;

    always #5 tb_clk = ~tb_clk;

    res_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    res_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit clr;
        bit wen;
        int din;
        bit ren;
        int exp_out;
        bit exp_rvalid;
        int exp_count;
        bit exp_empty;
        bit exp_ovf;
        bit exp_unf;
    } vec_t;

    int   num_checks = 0;
    int   num_fails  = 0;
    int   model_q[$];
    int   model_out;
    bit   model_rvalid;
    bit   model_ovf;
    bit   model_unf;
    vec_t vecs[$];

    task automatic check_val(input string name, input int actual, input int expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_out    = 0;
        model_rvalid = 1'b0;
        model_ovf    = 1'b0;
        model_unf    = 1'b0;
    endtask

    // Reference behaviour: a plain queue with capacity DEPTH.
    task automatic model_step(input bit clr, input bit wen, input int din, input bit ren);
        bit rd;
        bit wr;
        if (clr) begin
            model_reset();
            return;
        end
        rd = ren && (model_q.size() > 0);
        wr = wen && ((model_q.size() < DEPTH) || rd);
        if (rd) begin
            model_out    = model_q.pop_front();
            model_rvalid = 1'b1;
        end else begin
            model_out    = 0;
            model_rvalid = 1'b0;
        end
        if (ren && !rd) model_unf = 1'b1;
        if (wen && !wr) model_ovf = 1'b1;
        if (wr) model_q.push_back(din);
    endtask

    task automatic check_output(input string tag, input int exp_out, input bit exp_rvalid,
                                input int exp_count, input bit exp_empty,
                                input bit exp_ovf, input bit exp_unf);
        check_val({tag, ".result_out"}, int'(bus.result_out), exp_out);
        check_val({tag, ".rvalid"},     int'(bus.rvalid),     int'(exp_rvalid));
        check_val({tag, ".count"},      int'(bus.count),      exp_count);
        check_val({tag, ".empty"},      int'(bus.empty),      int'(exp_empty));
        check_val({tag, ".overflow"},   int'(bus.overflow),   int'(exp_ovf));
        check_val({tag, ".underflow"},  int'(bus.underflow),  int'(exp_unf));
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        check_output(tag, model_out, model_rvalid, n, n == 0, model_ovf, model_unf);
        check_val({tag, ".full"},        int'(bus.full),        int'(n == DEPTH));
        check_val({tag, ".almost_full"}, int'(bus.almost_full), int'(n >= AF_LEVEL));
    endtask

    // Called at a falling edge: drive, take one rising edge, idle the inputs, sample at the next falling edge.
    task automatic apply_stimulus(input bit clr, input bit wen, input int din, input bit ren);
        bus.clear     = clr;
        bus.wenable   = wen;
        bus.result_in = DATA_W'(din);
        bus.renable   = ren;
        @(posedge tb_clk);
        model_step(clr, wen, din, ren);
        #1;
        bus.clear   = 1'b0;
        bus.wenable = 1'b0;
        bus.renable = 1'b0;
        @(negedge tb_clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_output(tag, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val({tag, ".full"},        int'(bus.full),        0);
        check_val({tag, ".almost_full"}, int'(bus.almost_full), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.wenable   = 1'b0;
        bus.result_in = '0;
        bus.renable   = 1'b0;
        model_reset();

        #2;
        check_reset_values("reset_initial");
        @(negedge tb_clk);
        rst = 1'b0;
        @(negedge tb_clk);
        check_reset_values("reset_release");

        // Asynchronous reset in the middle of traffic discards stored words.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 300 + i, 1'b0);
            check_model("pre_reset_write");
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("reset_async");
        model_reset();
        @(negedge tb_clk);
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b1, 555, 1'b0);
        check_model("post_reset_write");
        apply_stimulus(1'b0, 1'b0, 0, 1'b1);
        check_val("post_reset_first_word", int'(bus.result_out), 555);
        check_model("post_reset_read");

        // Directed vectors: basic order, underflow, simultaneous on empty, clear.
        vecs.push_back(vec_t'{0, 1,   68, 0,    0, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 2021, 0,    0, 0, 2, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0,    0, 0,    0, 0, 2, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1,  984, 0,    0, 0, 3, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0,    0, 1,   68, 1, 2, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0,    0, 1, 2021, 1, 1, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0,    0, 1,  984, 1, 0, 1, 0, 0});
        vecs.push_back(vec_t'{0, 0,    0, 1,    0, 0, 0, 1, 0, 1});
        vecs.push_back(vec_t'{0, 1,    7, 1,    0, 0, 1, 0, 0, 1});
        vecs.push_back(vec_t'{0, 0,    0, 1,    7, 1, 0, 1, 0, 1});
        vecs.push_back(vec_t'{1, 0,    0, 0,    0, 0, 0, 1, 0, 0});
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(vec_t'{0, 1, 11 + i, 0, 0, 0, i + 1, 0, 0, 0});
        end
        vecs.push_back(vec_t'{1, 1,   99, 0,    0, 0, 0, 1, 0, 0});
        vecs.push_back(vec_t'{0, 0,    0, 1,    0, 0, 0, 1, 0, 1});
        vecs.push_back(vec_t'{1, 0,    0, 0,    0, 0, 0, 1, 0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].clr, vecs[i].wen, vecs[i].din, vecs[i].ren);
            check_output($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_rvalid,
                         vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Fill to capacity, then simultaneous read/write while full, then overflow.
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(1'b0, 1'b1, i, 1'b0);
            check_model("fill");
            if (i == AF_LEVEL - 1) check_val("almost_full_below", int'(bus.almost_full), 0);
            if (i == AF_LEVEL)     check_val("almost_full_at",    int'(bus.almost_full), 1);
        end
        check_val("full_after_fill", int'(bus.full), 1);
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b0, 1'b1, 5000 + k, 1'b1);
            check_val("simul_full_data", int'(bus.result_out), k + 1);
            check_model("simul_full");
        end
        check_val("simul_full_overflow", int'(bus.overflow), 0);
        apply_stimulus(1'b0, 1'b1, 2000, 1'b0);
        check_val("overflow_set", int'(bus.overflow), 1);
        check_val("overflow_count", int'(bus.count), DEPTH);
        check_model("overflow");
        for (int i = 0; i <= DEPTH; i++) begin
            apply_stimulus(1'b0, 1'b0, 0, 1'b1);
            check_model("drain");
        end

        // Randomized traffic, first write-biased then read-biased, with rare clears.
        for (int c = 0; c < 3000; c++) begin
            bit clr;
            bit wen;
            bit ren;
            clr = ($urandom_range(0, 299) == 0);
            wen = (c < 1500) ? ($urandom_range(0, 99) < 65) : ($urandom_range(0, 99) < 35);
            ren = (c < 1500) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 65);
            apply_stimulus(clr, wen, int'($urandom_range(0, 65535)), ren);
            check_model("random");
        end

        // Drain leaving the pointers offset, then fill and drain again across the wrap point.
        for (int i = 0; i <= DEPTH && model_q.size() > 0; i++) begin
            apply_stimulus(1'b0, 1'b0, 0, 1'b1);
            check_model("drain2");
        end
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(1'b0, 1'b1, i, 1'b0);
            check_model("refill");
        end
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(1'b0, 1'b0, 0, 1'b1);
            check_val("wrap_order", int'(bus.result_out), i);
            check_model("redrain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end
endmodule
